// File: rtl/spi_wb_bridge_pkg.sv
// Shared definitions for the SPI-to-Wishbone bridge: FSM encoding,
// command bytes, frame field lengths and the substitute read word.
package spi_wb_bridge_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_WDATA,
        ST_DUMMY,
        ST_RDATA,
        ST_BUS,
        ST_IGNORE
    } state_t;

    localparam logic [7:0]  CMD_WR       = 8'h80;
    localparam logic [7:0]  CMD_RD       = 8'h00;

    localparam int          CMD_BITS     = 8;
    localparam int          ADDR_BITS    = 32;
    localparam int          WDATA_BITS   = 32;
    localparam int          DUMMY_BITS   = 8;
    localparam int          RDATA_BITS   = 32;

    localparam logic [31:0] TIMEOUT_DATA = 32'hDEADBEEF;

    // Index of the last bit of the field that a shifting state receives.
    function automatic logic [5:0] phase_last(input state_t s);
        case (s)
            ST_CMD:   return 6'(CMD_BITS - 1);
            ST_ADDR:  return 6'(ADDR_BITS - 1);
            ST_WDATA: return 6'(WDATA_BITS - 1);
            ST_DUMMY: return 6'(DUMMY_BITS - 1);
            ST_RDATA: return 6'(RDATA_BITS - 1);
            default:  return 6'd0;
        endcase
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Brings the asynchronous SPI pins into the clk domain through 2-FF
// synchronizers and produces single-cycle edge strobes for SCK and CS.
module spi_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic spi_sck_i,
    input  logic spi_cs_n_i,
    input  logic spi_mosi_i,
    output logic sck_rise_o,
    output logic sck_fall_o,
    output logic cs_fall_o,
    output logic cs_rise_o,
    output logic mosi_o
);

    // Stages [1:0] synchronize, stage [2] holds the previous value for edges.
    logic [2:0] sck_q;
    logic [2:0] cs_q;
    logic [1:0] mosi_q;

    // Synchronizer chains; CS resets high so no false frame start follows reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            sck_q  <= 3'b000;
            cs_q   <= 3'b111;
            mosi_q <= 2'b00;
        end else begin
            sck_q  <= {sck_q[1:0], spi_sck_i};
            cs_q   <= {cs_q[1:0], spi_cs_n_i};
            mosi_q <= {mosi_q[0], spi_mosi_i};
        end
    end

    // MOSI has the same synchronizer depth as SCK, so it is aligned with sck_rise_o.
    assign sck_rise_o =  sck_q[1] & ~sck_q[2];
    assign sck_fall_o = ~sck_q[1] &  sck_q[2];
    assign cs_fall_o  = ~cs_q[1]  &  cs_q[2];
    assign cs_rise_o  =  cs_q[1]  & ~cs_q[2];
    assign mosi_o     =  mosi_q[1];

endmodule

// File: rtl/spi_wb_bridge.sv
// SPI mode-0 slave that turns write/read frames into single Wishbone
// classic bus cycles, with an ack timeout and a sticky error flag.
module spi_wb_bridge
    import spi_wb_bridge_pkg::*;
#(
    parameter int TIMEOUT = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        spi_sck,
    input  logic        spi_cs_n,
    input  logic        spi_mosi,
    output logic        spi_miso,
    output logic        spi_miso_oe,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    output logic [3:0]  wb_sel_o,
    output logic        wb_we_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    input  logic        wb_ack_i,
    output logic        err_o
);

    logic sck_rise, sck_fall, cs_fall, cs_rise, mosi_s;

    spi_sync_edge u_sync (
        .clk        (clk),
        .rst        (rst),
        .spi_sck_i  (spi_sck),
        .spi_cs_n_i (spi_cs_n),
        .spi_mosi_i (spi_mosi),
        .sck_rise_o (sck_rise),
        .sck_fall_o (sck_fall),
        .cs_fall_o  (cs_fall),
        .cs_rise_o  (cs_rise),
        .mosi_o     (mosi_s)
    );

    state_t      state_q, state_d;
    logic [5:0]  bit_cnt_q;
    logic [30:0] shift_q;
    logic [31:0] addr_q, wdata_q, miso_sr_q, to_cnt_q, adr_q, dat_q;
    logic        is_wr_q, req_pend_q, req_we_q, own_q, rd_valid_q;
    logic        cyc_q, we_q, err_q, miso_q;

    logic        shifting, phase_done, cmd_ok, abort, req_set;
    logic        bus_ack, bus_to, bus_end, rd_capture, rd_miss;
    logic [7:0]  cmd_byte;
    logic [31:0] word_in, first_word, miso_src;

    assign shifting   = state_q inside {ST_CMD, ST_ADDR, ST_WDATA, ST_DUMMY, ST_RDATA};
    assign phase_done = shifting && sck_rise && (bit_cnt_q == phase_last(state_q));
    assign cmd_byte   = {shift_q[6:0], mosi_s};
    assign word_in    = {shift_q, mosi_s};
    assign cmd_ok     = (cmd_byte == CMD_WR) || (cmd_byte == CMD_RD);
    // A CS rise ends the frame, except in BUS where the write is already complete.
    assign abort      = cs_rise && (state_q != ST_BUS);
    assign req_set    = phase_done && !cs_rise &&
                        (((state_q == ST_ADDR) && !is_wr_q) || (state_q == ST_WDATA));
    assign bus_ack    = cyc_q && wb_ack_i;
    assign bus_to     = cyc_q && !wb_ack_i && (to_cnt_q == 32'(TIMEOUT - 1));
    assign bus_end    = bus_ack || bus_to;
    // Read data is only taken while the dummy byte is still running for this frame.
    assign rd_capture = bus_end && own_q && !we_q && (state_q == ST_DUMMY);
    assign first_word = rd_valid_q ? miso_sr_q : TIMEOUT_DATA;
    assign miso_src   = (bit_cnt_q == 6'd0) ? first_word : miso_sr_q;
    assign rd_miss    = (state_q == ST_RDATA) && sck_fall && (bit_cnt_q == 6'd0) && !rd_valid_q;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic: field lengths drive the phase sequence, CS rise aborts.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (cs_fall) state_d = ST_CMD;
            ST_BUS: begin
                if (!req_pend_q && !cyc_q) state_d = ST_IDLE;
                else if (cs_fall)          state_d = ST_CMD;
            end
            default: begin
                if (cs_rise) begin
                    state_d = ST_IDLE;
                end else if (phase_done) begin
                    case (state_q)
                        ST_CMD:   state_d = cmd_ok ? ST_ADDR : ST_IGNORE;
                        ST_ADDR:  state_d = is_wr_q ? ST_WDATA : ST_DUMMY;
                        ST_WDATA: state_d = ST_BUS;
                        ST_DUMMY: state_d = ST_RDATA;
                        default:  state_d = ST_IDLE;
                    endcase
                end
            end
        endcase
    end

    // Serial receive path: bit counter, MOSI shifter and field capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt_q <= 6'd0;
            shift_q   <= 31'd0;
            is_wr_q   <= 1'b0;
            addr_q    <= 32'd0;
            wdata_q   <= 32'd0;
        end else begin
            if (cs_fall || cs_rise || (state_d != state_q)) bit_cnt_q <= 6'd0;
            else if (shifting && sck_rise)                 bit_cnt_q <= bit_cnt_q + 6'd1;
            if (shifting && sck_rise) shift_q <= word_in[30:0];
            if ((state_q == ST_CMD) && phase_done && cmd_ok) is_wr_q <= (cmd_byte == CMD_WR);
            if ((state_q == ST_ADDR) && phase_done)  addr_q  <= word_in;
            if ((state_q == ST_WDATA) && phase_done) wdata_q <= word_in;
        end
    end

    // Wishbone master: one pending request, started only once the bus is idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            req_pend_q <= 1'b0;
            req_we_q   <= 1'b0;
            cyc_q      <= 1'b0;
            we_q       <= 1'b0;
            own_q      <= 1'b0;
            adr_q      <= 32'd0;
            dat_q      <= 32'd0;
            to_cnt_q   <= 32'd0;
        end else begin
            if (req_set) begin
                req_pend_q <= 1'b1;
                req_we_q   <= (state_q == ST_WDATA);
            end else if (abort || !cyc_q) begin
                req_pend_q <= 1'b0;
            end
            if (cyc_q) begin
                to_cnt_q <= to_cnt_q + 32'd1;
                if (bus_end) begin
                    cyc_q    <= 1'b0;
                    we_q     <= 1'b0;
                    own_q    <= 1'b0;
                    to_cnt_q <= 32'd0;
                end else if (cs_rise) begin
                    own_q    <= 1'b0;
                end
            end else if (req_pend_q && !abort) begin
                cyc_q    <= 1'b1;
                we_q     <= req_we_q;
                adr_q    <= addr_q;
                dat_q    <= wdata_q;
                to_cnt_q <= 32'd0;
                own_q    <= 1'b1;
            end
        end
    end

    // Read return path and error flag; MISO only moves on SCK falls in RDATA.
    always_ff @(posedge clk) begin
        if (rst) begin
            miso_sr_q  <= 32'd0;
            miso_q     <= 1'b0;
            rd_valid_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            if (req_set) begin
                rd_valid_q <= 1'b0;
            end else if (rd_capture) begin
                rd_valid_q <= 1'b1;
                miso_sr_q  <= bus_ack ? wb_dat_i : TIMEOUT_DATA;
            end
            if (state_q == ST_RDATA) begin
                if (sck_fall) begin
                    miso_q    <= miso_src[31];
                    miso_sr_q <= {miso_src[30:0], 1'b0};
                end
            end else begin
                miso_q <= 1'b0;
            end
            if (bus_to || rd_miss)                                      err_q <= 1'b1;
            else if ((state_q == ST_CMD) && phase_done && cmd_ok && !cs_rise) err_q <= 1'b0;
        end
    end

    assign spi_miso    = miso_q && (state_q == ST_RDATA);
    assign spi_miso_oe = ~spi_cs_n;
    assign wb_adr_o    = adr_q;
    assign wb_dat_o    = dat_q;
    assign wb_sel_o    = 4'hF;
    assign wb_we_o     = we_q;
    assign wb_cyc_o    = cyc_q;
    assign wb_stb_o    = cyc_q;
    assign err_o       = err_q;

endmodule

// File: doc/spi_wb_bridge.md
SPI_WB_BRIDGE -- requirements
Module: spi_wb_bridge

Interface
REQ-001 SHALL have parameter TIMEOUT, default 256, meaning the maximum clk cycles to wait for wb_ack_i before aborting a bus cycle.
REQ-002 SHALL have ports (name, direction, width, meaning):
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- spi_sck  in  1  external SPI clock, asynchronous to clk
- spi_cs_n  in  1  chip select, active-low, asynchronous
- spi_mosi  in  1  serial data from the host
- spi_miso  out  1  serial data to the host
- spi_miso_oe  out  1  high while spi_cs_n is low (top-level tristate enable)
- wb_adr_o  out  32  Wishbone address
- wb_dat_o  out  32  Wishbone write data
- wb_dat_i  in  32  Wishbone read data
- wb_sel_o  out  4  byte select, always 4'hF
- wb_we_o  out  1  write enable
- wb_cyc_o  out  1  cycle
- wb_stb_o  out  1  strobe
- wb_ack_i  in  1  acknowledge
- err_o  out  1  sticky timeout flag, cleared at the start of the next valid frame

Function
REQ-003 SHALL be an SPI mode-0 slave: sample MOSI on rising SCK edges, change MISO on falling SCK edges, and transfer MSB first.
REQ-004 SHALL pass spi_sck, spi_cs_n and spi_mosi through 2-FF synchronizers and detect edges in the clk domain; correct operation requires f_clk >= 8*f_sck.
REQ-005 SHALL use this frame format:
- write: cmd(8) + addr(32) + data(32)
- read: cmd(8) + addr(32) + dummy(8) + data-out(32)
REQ-006 SHALL decode the command byte as follows:
- 0x80 = write, 0x00 = read
- any other value makes the frame ignored (no bus cycle, MISO 0) until CS deasserts.
REQ-007 SHALL implement FSM states IDLE, CMD, ADDR, WDATA, DUMMY, RDATA, BUS, IGNORE.
- CS falling: IDLE->CMD.
- 8 bits: CMD->ADDR, or CMD->IGNORE if the command is invalid.
- 32 bits: ADDR->WDATA (write) or ADDR->DUMMY (read).
- 32 bits: WDATA->BUS.
- 8 bits: DUMMY->RDATA.
- 32 bits: RDATA->IDLE.
- BUS completion: ->IDLE.
REQ-008 SHALL assert wb_cyc_o and wb_stb_o together, hold them with a stable address, data and wb_we_o until wb_ack_i or timeout, and deassert both on the cycle after the ack is seen.
REQ-009 SHALL, for a write, start the bus cycle within 2 clk cycles of sampling the 72nd bit.
REQ-010 SHALL, for a read, start the bus cycle within 2 clk cycles of sampling the 40th bit, and latch wb_dat_i on ack into a 32-bit shift register.
REQ-011 SHALL present read data bit 31 on MISO by the falling SCK edge that ends the dummy byte.
REQ-012 SHALL handle a read bus cycle that has not completed by the end of the dummy byte by shifting out 0xDEADBEEF and setting err_o.
REQ-013 SHALL maintain a timeout counter that counts clk cycles while wb_cyc_o is high; on reaching TIMEOUT-1 it SHALL drop cyc/stb, set err_o, and substitute 0xDEADBEEF as read data.
REQ-014 SHALL handle spi_cs_n deasserting mid-frame as follows:
- the FSM returns to IDLE and the bit counter clears;
- no new bus cycle starts;
- a bus cycle already in flight runs to ack or timeout and is then dropped.
REQ-015 SHALL restart cleanly at CMD if CS falls again while a prior bus cycle is still completing; the new bus request waits until wb_cyc_o is low.
REQ-016 SHALL drive spi_miso to 0 outside RDATA.
REQ-017 SHALL keep wb_sel_o constant at 4'hF; no burst or auto-increment is supported.

Reset
REQ-018 SHALL, while rst is high at a clk edge, set:
- FSM to IDLE and all counters to 0;
- wb_cyc_o, wb_stb_o, wb_we_o, err_o, spi_miso to 0;
- wb_adr_o and wb_dat_o to 0.
REQ-019 SHALL abandon any in-flight bus cycle immediately on rst, without waiting for ack.
REQ-020 SHALL initialise the synchronizer flops so that CS reads as deasserted (1) after reset.

Structure
REQ-021 SHALL place the FSM state encoding, command constants (CMD_WR=0x80, CMD_RD=0x00), frame bit counts (8/32/8/32) and TIMEOUT_DATA=0xDEADBEEF in a shared package.
REQ-022 SHALL contain exactly one sub-module, spi_sync_edge, holding the 2-FF synchronizers and the SCK rise/fall and CS fall/rise detectors.

Verification
REQ-023 The bench SHALL cover these scenarios:
- Write frame cmd 0x80, addr 0x40000000, data 0x12345678, slave acks after 3 cycles -> one WB write with adr 0x40000000, dat 0x12345678, sel 0xF, we 1; err_o 0.
- Read frame cmd 0x00, addr 0x20000004, slave returns 0xCAFEF00D after 5 cycles -> host shifts in 0xCAFEF00D; exactly one WB read.
- Read to addr 0x90000000 with no ack -> cyc drops after 256 cycles; err_o 1; host receives 0xDEADBEEF.
- CS deasserted after 20 bits of a write -> no WB cycle; next valid write completes normally.
- Command 0x81 with 72 bits clocked -> no WB cycle; MISO 0 throughout.
- rst pulsed while a write cycle is waiting for ack -> cyc/stb/we 0 on the next clk; FSM IDLE.
